// File: rtl/rv_fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches under a credit limit,
// buffers in-order responses in a prefetch FIFO and flushes on branch redirect.
module rv_fetch_unit #(
   parameter int              XLEN       = 64,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [31:0]     imem_rsp_data_i,
   output logic            if_valid_o,
   input  logic            if_ready_i,
   output logic [31:0]     if_instr_o,
   output logic [XLEN-1:0] if_pc_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0]     CREDITS = (CW + 1)'(FIFO_DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [31:0]     fifo_instr_q [FIFO_DEPTH];
   logic [XLEN-1:0] fifo_pc_q [FIFO_DEPTH];
   logic [CW:0]     occupancy;
   logic [XLEN-1:0] target_pc;
   logic            req_fire, push, discard, pop;
   logic            unused_pc_lsb;

   // Target low bits are forced to word alignment.
   assign target_pc     = {redirect_pc_i[XLEN-1:2], 2'b00};
   assign unused_pc_lsb = ^redirect_pc_i[1:0];

   // Every request reserves a FIFO slot, so pushes can never overflow.
   assign occupancy        = {1'b0, count_q} + {1'b0, inflight_q};
   assign imem_req_valid_o = rstn && !redirect_i && (occupancy < CREDITS);
   assign imem_req_addr_o  = fetch_pc_q;
   assign req_fire         = imem_req_valid_o && imem_req_ready_i;

   assign push    = imem_rsp_valid_i && !redirect_i && (drop_q == '0);
   assign discard = imem_rsp_valid_i && !redirect_i && (drop_q != '0);
   assign pop     = if_valid_o && if_ready_i && !redirect_i;

   assign if_valid_o = (count_q != '0);
   assign if_instr_o = if_valid_o ? fifo_instr_q[rd_ptr_q] : '0;
   assign if_pc_o    = if_valid_o ? fifo_pc_q[rd_ptr_q] : '0;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (discard)  drop_d = drop_q - CW'(1);
      if (push) begin
         rsp_pc_d = rsp_pc_q + PC_STEP;
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      // Redirect empties the FIFO and marks every still-outstanding request as stale.
      if (redirect_i) begin
         fetch_pc_d = target_pc;
         rsp_pc_d   = target_pc;
         count_d    = '0;
         rd_ptr_d   = wr_ptr_q;
         wr_ptr_d   = wr_ptr_q;
         drop_d     = inflight_q - CW'(imem_rsp_valid_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[wr_ptr_q] <= imem_rsp_data_i;
         fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
      end
   end
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: a latency-configurable instruction memory model plus a
// program-order model of the fetched stream (sequential PCs restarting at each redirect).
module tb_rv_fetch_unit;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        redirect_i = 1'b0;
   logic [63:0] redirect_pc_i = '0;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i = 1'b0;
   logic [63:0] imem_req_addr_o;
   logic        imem_rsp_valid_i = 1'b0;
   logic [31:0] imem_rsp_data_i = '0;
   logic        if_valid_o;
   logic        if_ready_i = 1'b0;
   logic [31:0] if_instr_o;
   logic [63:0] if_pc_o;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int ready_pct = 100;
   int lat_min = 1;
   int lat_max = 1;
   int cyc = 0;
   logic [63:0] imem_q[$];
   int          due_q[$];
   logic [63:0] req_q[$];
   logic [63:0] exp_q[$];

   rv_fetch_unit #(.XLEN(64), .RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rstn(rstn), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
      .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
      .imem_rsp_data_i(imem_rsp_data_i), .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
      .if_instr_o(if_instr_o), .if_pc_o(if_pc_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] ^ a[63:32]) * 32'h9e37_79b1 + 32'h13;
   endfunction

   // Instruction memory: records accepted requests, answers in order after lat cycles.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rstn) begin
         imem_q.delete();
         due_q.delete();
         req_q.delete();
      end else if (imem_req_valid_o && imem_req_ready_i) begin
         imem_q.push_back(imem_req_addr_o);
         due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)) - 1);
         req_q.push_back(imem_req_addr_o);
      end
   end

   always @(negedge clk) begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
      if (rstn && imem_q.size() != 0 && due_q[0] <= cyc) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = mem_word(imem_q.pop_front());
         void'(due_q.pop_front());
      end
      imem_req_ready_i = (int'($urandom_range(99)) < ready_pct);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; redirect_i = 1'b0; if_ready_i = 1'b0;
      ready_pct = 100; lat_min = 1; lat_max = 1;
      repeat (2) tick();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; redirect_i = 1'b0; if_ready_i = 1'b0;
      repeat (2) tick();
      chk_cnt++; if (imem_req_valid_o !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", imem_req_valid_o); else pass_cnt++;
      chk_cnt++; if (if_valid_o !== 1'b0) $display("FAIL reset_if_valid: got %b want 0", if_valid_o); else pass_cnt++;
      chk_cnt++; if (if_instr_o !== 32'h0) $display("FAIL reset_if_instr: got %h want 0", if_instr_o); else pass_cnt++;
      chk_cnt++; if (if_pc_o !== 64'h0) $display("FAIL reset_if_pc: got %h want 0", if_pc_o); else pass_cnt++;
      rstn = 1'b1;
      #1;
      chk_cnt++; if (imem_req_valid_o !== 1'b1) $display("FAIL release_req_valid: got %b want 1", imem_req_valid_o); else pass_cnt++;
      chk_cnt++; if (imem_req_addr_o !== RESET_PC) $display("FAIL release_req_addr: got %h want %h", imem_req_addr_o, RESET_PC); else pass_cnt++;
   endtask

   task automatic test_stream();
      logic [63:0] exp_pc;
      int pops, gaps;
      bit seen;
      exp_pc = RESET_PC; pops = 0; gaps = 0; seen = 0;
      do_reset();
      if_ready_i = 1'b1;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (if_valid_o) begin
            chk_cnt++; if (if_pc_o !== exp_pc) $display("FAIL stream_pc: got %h want %h", if_pc_o, exp_pc); else pass_cnt++;
            chk_cnt++; if (if_instr_o !== mem_word(exp_pc)) $display("FAIL stream_instr: got %h want %h", if_instr_o, mem_word(exp_pc)); else pass_cnt++;
            exp_pc += 64'd4; pops++; seen = 1;
         end else if (seen) gaps++;
      end
      chk_cnt++; if (gaps != 0) $display("FAIL stream_gaps: got %0d want 0", gaps); else pass_cnt++;
      chk_cnt++; if (pops != 23) $display("FAIL stream_pops: got %0d want 23", pops); else pass_cnt++;
      for (int i = 0; i < req_q.size(); i++) begin
         chk_cnt++; if (req_q[i] !== 64'(4 * i)) $display("FAIL stream_req_addr: got %h want %h", req_q[i], 64'(4 * i)); else pass_cnt++;
      end
   endtask

   task automatic test_stall();
      logic [63:0] e;
      do_reset();
      if_ready_i = 1'b0;
      repeat (10) tick();
      chk_cnt++; if (req_q.size() != 4) $display("FAIL stall_req_count: got %0d want 4", req_q.size()); else pass_cnt++;
      chk_cnt++; if (imem_req_valid_o !== 1'b0) $display("FAIL stall_req_valid: got %b want 0", imem_req_valid_o); else pass_cnt++;
      chk_cnt++; if (if_valid_o !== 1'b1) $display("FAIL stall_if_valid: got %b want 1", if_valid_o); else pass_cnt++;
      exp_q = {64'h0, 64'h4, 64'h8, 64'hc, 64'h10};
      if_ready_i = 1'b1;
      for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
         if (if_valid_o) begin
            e = exp_q.pop_front();
            chk_cnt++; if (if_pc_o !== e) $display("FAIL stall_pc: got %h want %h", if_pc_o, e); else pass_cnt++;
            chk_cnt++; if (if_instr_o !== mem_word(e)) $display("FAIL stall_instr: got %h want %h", if_instr_o, mem_word(e)); else pass_cnt++;
         end
         tick();
      end
      chk_cnt++; if (exp_q.size() != 0) $display("FAIL stall_lost: got %0d left want 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_redirect();
      logic [63:0] e;
      int n;
      do_reset();
      lat_min = 5; lat_max = 5; if_ready_i = 1'b1;
      for (int i = 0; i < 10 && req_q.size() < 3; i++) tick();
      chk_cnt++; if (req_q.size() != 3) $display("FAIL redir_inflight: got %0d want 3", req_q.size()); else pass_cnt++;
      redirect_i = 1'b1; redirect_pc_i = 64'h100;
      #1;
      chk_cnt++; if (imem_req_valid_o !== 1'b0) $display("FAIL redir_req_valid: got %b want 0", imem_req_valid_o); else pass_cnt++;
      tick();
      redirect_i = 1'b0;
      #1;
      chk_cnt++; if (imem_req_valid_o !== 1'b1) $display("FAIL redir_next_valid: got %b want 1", imem_req_valid_o); else pass_cnt++;
      chk_cnt++; if (imem_req_addr_o !== 64'h100) $display("FAIL redir_next_addr: got %h want 100", imem_req_addr_o); else pass_cnt++;
      e = 64'h100; n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         if (if_valid_o) begin
            chk_cnt++; if (if_pc_o !== e) $display("FAIL redir_pc: got %h want %h", if_pc_o, e); else pass_cnt++;
            chk_cnt++; if (if_instr_o !== mem_word(e)) $display("FAIL redir_instr: got %h want %h", if_instr_o, mem_word(e)); else pass_cnt++;
            e += 64'd4; n++;
         end
         tick();
      end
      chk_cnt++; if (n != 4) $display("FAIL redir_timeout: got %0d pops want 4", n); else pass_cnt++;
      chk_cnt++; if (req_q.size() < 4 || req_q[3] !== 64'h100) $display("FAIL redir_req_order: got %0d reqs want 4th addr 100", req_q.size()); else pass_cnt++;
   endtask

   task automatic test_redirect_same();
      logic [63:0] e;
      int n;
      do_reset();
      lat_min = 2; lat_max = 2; if_ready_i = 1'b1;
      for (int i = 0; i < 20 && !(if_valid_o && imem_rsp_valid_i); i++) tick();
      chk_cnt++; if (!(if_valid_o && imem_rsp_valid_i)) $display("FAIL same_setup: got valid=%b rsp=%b want both 1", if_valid_o, imem_rsp_valid_i); else pass_cnt++;
      redirect_i = 1'b1; redirect_pc_i = 64'h200;
      tick();
      redirect_i = 1'b0;
      chk_cnt++; if (if_valid_o !== 1'b0) $display("FAIL same_flush: got %b want 0", if_valid_o); else pass_cnt++;
      tick();
      chk_cnt++; if (if_valid_o !== 1'b0) $display("FAIL same_stale_drop: got %b want 0", if_valid_o); else pass_cnt++;
      e = 64'h200; n = 0;
      for (int i = 0; i < 30 && n < 3; i++) begin
         if (if_valid_o) begin
            chk_cnt++; if (if_pc_o !== e) $display("FAIL same_pc: got %h want %h", if_pc_o, e); else pass_cnt++;
            chk_cnt++; if (if_instr_o !== mem_word(e)) $display("FAIL same_instr: got %h want %h", if_instr_o, mem_word(e)); else pass_cnt++;
            e += 64'd4; n++;
         end
         tick();
      end
      chk_cnt++; if (n != 3) $display("FAIL same_timeout: got %0d pops want 3", n); else pass_cnt++;
   endtask

   task automatic test_req_stall();
      do_reset();
      if_ready_i = 1'b1;
      for (int i = 0; i < 10 && req_q.size() < 1; i++) tick();
      ready_pct = 0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk_cnt++; if (imem_req_valid_o !== 1'b1) $display("FAIL rstall_valid: got %b want 1", imem_req_valid_o); else pass_cnt++;
         chk_cnt++; if (imem_req_addr_o !== 64'h8) $display("FAIL rstall_addr: got %h want 8", imem_req_addr_o); else pass_cnt++;
         chk_cnt++; if (req_q.size() != 2) $display("FAIL rstall_count: got %0d want 2", req_q.size()); else pass_cnt++;
         if (i == 4) ready_pct = 100;
         tick();
      end
      repeat (3) tick();
      chk_cnt++; if (req_q.size() < 4 || req_q[2] !== 64'h8 || req_q[3] !== 64'hc) $display("FAIL rstall_resume: got %0d reqs want addrs 8,c next", req_q.size()); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      lat_min = 1; lat_max = 3; if_ready_i = 1'b1;
      repeat (10) tick();
      rstn = 1'b0;
      #1;
      chk_cnt++; if (imem_req_valid_o !== 1'b0) $display("FAIL mid_rst_req_valid: got %b want 0", imem_req_valid_o); else pass_cnt++;
      tick();
      rstn = 1'b1;
      #1;
      chk_cnt++; if (if_valid_o !== 1'b0) $display("FAIL mid_rst_if_valid: got %b want 0", if_valid_o); else pass_cnt++;
      chk_cnt++; if (imem_req_addr_o !== RESET_PC) $display("FAIL mid_rst_addr: got %h want %h", imem_req_addr_o, RESET_PC); else pass_cnt++;
      chk_cnt++; if (if_pc_o !== 64'h0) $display("FAIL mid_rst_if_pc: got %h want 0", if_pc_o); else pass_cnt++;
      n = 0;
      for (int i = 0; i < 20 && n == 0; i++) begin
         tick();
         if (if_valid_o) begin
            chk_cnt++; if (if_pc_o !== RESET_PC) $display("FAIL mid_rst_first_pc: got %h want %h", if_pc_o, RESET_PC); else pass_cnt++;
            chk_cnt++; if (if_instr_o !== mem_word(RESET_PC)) $display("FAIL mid_rst_first_instr: got %h want %h", if_instr_o, mem_word(RESET_PC)); else pass_cnt++;
            n++;
         end
      end
      chk_cnt++; if (n != 1) $display("FAIL mid_rst_timeout: got %0d pops want 1", n); else pass_cnt++;
   endtask

   task automatic test_random();
      logic [63:0] exp_pc, exp_req, a, tgt;
      bit rdr;
      int pops;
      exp_pc = RESET_PC; exp_req = RESET_PC; pops = 0;
      do_reset();
      lat_min = 1; lat_max = 4; ready_pct = 60;
      for (int c = 0; c < 800; c++) begin
         tick();
         while (req_q.size() != 0) begin
            a = req_q.pop_front();
            chk_cnt++; if (a !== exp_req) $display("FAIL rand_req_addr: got %h want %h", a, exp_req); else pass_cnt++;
            exp_req += 64'd4;
         end
         rdr = (int'($urandom_range(99)) < 4);
         tgt = {$urandom(), $urandom()};
         if ($urandom_range(3) == 0) tgt = 64'hffff_ffff_ffff_fff0 | {60'h0, tgt[3:0]};
         if_ready_i = (int'($urandom_range(99)) < 70);
         redirect_i = rdr;
         redirect_pc_i = tgt;
         if (if_valid_o) begin
            chk_cnt++; if (if_pc_o !== exp_pc) $display("FAIL rand_pc: got %h want %h", if_pc_o, exp_pc); else pass_cnt++;
            chk_cnt++; if (if_instr_o !== mem_word(exp_pc)) $display("FAIL rand_instr: got %h want %h", if_instr_o, mem_word(exp_pc)); else pass_cnt++;
            if (if_ready_i && !rdr) begin
               exp_pc += 64'd4;
               pops++;
            end
         end
         if (rdr) begin
            exp_pc  = {tgt[63:2], 2'b00};
            exp_req = exp_pc;
         end
      end
      redirect_i = 1'b0;
      chk_cnt++; if (pops < 100) $display("FAIL rand_throughput: got %0d pops want >=100", pops); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_same();
      test_req_stall();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
